lane_join_vector: RTL and testbench
===================================

LANE_JOIN_VECTOR -- requirements
Module: lane_join_vector

Interface
REQ-001 SHALL provide parameter N, default 32, element width in bits.
REQ-002 SHALL provide parameter V, default 20, elements per full vector.
REQ-003 SHALL provide parameter LANES, default 4, parallel lane results per beat; BEATS = V/LANES (5 by default).
REQ-004 SHALL provide port CLK  input  1  rising-edge clock for all state.
REQ-005 SHALL provide port RST  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port start_i  input  1  begin collecting a new vector.
REQ-007 SHALL provide port lane_valid_i  input  1  Res_i holds one beat of lane results.
REQ-008 SHALL provide port Res_i  input  [LANES-1:0][N-1:0]  per-lane ALU results.
REQ-009 SHALL provide port out_ready_i  input  1  consumer (register-file write-back) accepts Vec_o.
REQ-010 SHALL provide port Vec_o  output  [V-1:0][N-1:0]  assembled vector.
REQ-011 SHALL provide port vec_valid_o  output  1  Vec_o complete and stable.
REQ-012 SHALL provide port busy_o  output  1  high in COLLECT or HOLD.
REQ-013 SHALL provide port beat_o  output  3  index of the next beat to capture.
REQ-014 SHALL provide port err_o  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement states IDLE, COLLECT and HOLD, all transitions on the rising CLK edge.
REQ-016 In IDLE, start_i=1 SHALL move to COLLECT with beat=0; lane_valid_i is not captured in that cycle.
REQ-017 In COLLECT, lane_valid_i=1 SHALL write Res_i[L] into Vec_o[L*BEATS+beat] for every L, then increment beat.
REQ-018 In COLLECT, lane_valid_i=0 SHALL stall the block: beat and Vec_o are unchanged.
REQ-019 A capture at beat=BEATS-1 SHALL write the last beat, wrap beat to 0, enter HOLD and set vec_valid_o=1 on the following cycle.
REQ-020 In HOLD, Vec_o and vec_valid_o SHALL remain stable until out_ready_i=1.
REQ-021 In HOLD with out_ready_i=1 and start_i=0, the block SHALL enter IDLE and clear vec_valid_o on the next cycle.
REQ-022 In HOLD with out_ready_i=1 and start_i=1, the block SHALL enter COLLECT directly with beat=0.
REQ-023 start_i in COLLECT, or in HOLD without out_ready_i, SHALL be ignored.
REQ-024 Vec_o elements not yet overwritten SHALL retain their previous values.
REQ-025 The minimum latency SHALL be start_i accepted at cycle 0, beats captured at cycles 1-5, and vec_valid_o=1 at cycle 6.
REQ-026 busy_o and vec_valid_o SHALL be registered, with no combinational path from any input.

Reset
REQ-027 RST=0 at a rising edge SHALL force IDLE, beat_o=0, vec_valid_o=0, busy_o=0, err_o=0 and all Vec_o elements to 0.
REQ-028 Reset SHALL take priority over every input, including mid-COLLECT and HOLD; a partial vector is discarded.
REQ-029 After RST returns to 1, the block SHALL require a new start_i before it captures anything.

Configuration
REQ-030 With macro LANE_JOIN_ERR_EN defined, err_o SHALL set one cycle after lane_valid_i=1 occurs outside COLLECT.
REQ-031 With LANE_JOIN_ERR_EN defined, err_o SHALL stay set until reset or an accepted start_i.
REQ-032 Without LANE_JOIN_ERR_EN, err_o SHALL be tied to 0 and no error logic SHALL be synthesized.

Verification
REQ-033 Full vector: start_i, then 5 consecutive beats with Res_i[L]=100*L+b -> element 7 (L=1,b=2) = 102; vec_valid_o=1 at cycle 6.
REQ-034 Stall: lane_valid_i low for 3 cycles after beat 2 -> beat_o holds at 3; vec_valid_o rises at cycle 9.
REQ-035 Backpressure: out_ready_i=0 for 4 cycles in HOLD -> Vec_o unchanged; out_ready_i=1 -> IDLE next cycle, vec_valid_o=0.
REQ-036 Back-to-back: out_ready_i=1 and start_i=1 together in HOLD -> COLLECT, beat_o=0; second vector completes 5 beats later.
REQ-037 Mid-operation reset: RST=0 at beat 3 -> Vec_o all 0, IDLE; lane_valid_i=1 afterwards without start_i -> no capture.
REQ-038 Error flag (LANE_JOIN_ERR_EN defined): lane_valid_i=1 in IDLE -> err_o=1 next cycle; start_i -> err_o=0.

Source files
------------

// File: rtl/lane_join_vector.sv
// lane_join_vector: gathers LANES parallel lane results per beat into one
// V-element vector over BEATS = V/LANES beats, then holds it until the
// write-back consumer accepts it. Lane L fills elements L*BEATS .. L*BEATS+BEATS-1.
// Optional feature: define LANE_JOIN_ERR_EN to build the sticky protocol-error
// flag err_o; without it err_o is tied low.
module lane_join_vector #(
    parameter int N     = 32,
    parameter int V     = 20,
    parameter int LANES = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start_i,
    input  logic                      lane_valid_i,
    input  logic [LANES-1:0][N-1:0]   Res_i,
    input  logic                      out_ready_i,
    output logic [V-1:0][N-1:0]       Vec_o,
    output logic                      vec_valid_o,
    output logic                      busy_o,
    output logic [2:0]                beat_o,
    output logic                      err_o
);

    localparam int         BEATS     = V / LANES;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t     state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic       capture;

    // Next-state, beat counter and capture strobe.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COLLECT;
                    beat_d  = 3'd0;
                end
            end
            COLLECT: begin
                if (lane_valid_i) begin
                    capture = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 3'd0;
                        state_d = HOLD;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                // Accepting the vector and a new start together skips IDLE.
                if (out_ready_i) begin
                    state_d = start_i ? COLLECT : IDLE;
                    beat_d  = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 3'd0;
            end
        endcase
    end

    // Control state; status outputs are registered from the next state so
    // they have no combinational path from any input.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            beat_q      <= 3'd0;
            vec_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            vec_valid_o <= (state_d == HOLD);
            busy_o      <= (state_d != IDLE);
        end
    end

    assign beat_o = beat_q;

    // Vector storage: each capture writes one element per lane; elements
    // not addressed keep their value. Reset clears the whole vector.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            Vec_o <= '0;
        end else if (capture) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_q == 3'(b)) begin
                    for (int l = 0; l < LANES; l++) begin
                        Vec_o[l*BEATS + b] <= Res_i[l];
                    end
                end
            end
        end
    end

`ifdef LANE_JOIN_ERR_EN
    logic start_ok;
    logic err_q;

    assign start_ok = start_i && ((state_q == IDLE) ||
                                  (state_q == HOLD && out_ready_i));

    // Sticky error: lane data arriving outside COLLECT sets it (a new error
    // wins over a simultaneous clear); an accepted start clears it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else if (lane_valid_i && (state_q != COLLECT)) begin
            err_q <= 1'b1;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lane_join_vector.sv
// Self-checking bench for lane_join_vector: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the vector
// assembly (element store indexed by lane and beat, a mode, a beat count).
module tb_lane_join_vector;

    localparam int N     = 32;
    localparam int V     = 20;
    localparam int LANES = 4;
    localparam int BEATS = V / LANES;
    localparam int W     = V * N;

    logic                    CLK = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic                    lv = 1'b0;
    logic                    rdy = 1'b0;
    logic [LANES-1:0][N-1:0] res = '0;
    logic [V-1:0][N-1:0]     Vec_o;
    logic                    vec_valid_o, busy_o, err_o;
    logic [2:0]              beat_o;

    lane_join_vector #(.N(N), .V(V), .LANES(LANES)) dut (
        .CLK          (CLK),
        .RST          (rst),
        .start_i      (start),
        .lane_valid_i (lv),
        .Res_i        (res),
        .out_ready_i  (rdy),
        .Vec_o        (Vec_o),
        .vec_valid_o  (vec_valid_o),
        .busy_o       (busy_o),
        .beat_o       (beat_o),
        .err_o        (err_o)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: 0 = idle, 1 = collecting, 2 = holding a full vector.
    int                  m_mode = 0;
    int                  m_cnt  = 0;
    logic [V-1:0][N-1:0] m_vec  = '0;
    bit                  m_err  = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit new_err, accepted;
        new_err  = lv && (m_mode != 1);
        accepted = start && (m_mode == 0 || (m_mode == 2 && rdy));
        if (!rst) begin
            m_mode = 0; m_cnt = 0; m_vec = '0; m_err = 1'b0;
        end else begin
            case (m_mode)
                0: if (start) begin m_mode = 1; m_cnt = 0; end
                1: if (lv) begin
                       for (int l = 0; l < LANES; l++) m_vec[l*BEATS + m_cnt] = res[l];
                       m_cnt++;
                       if (m_cnt == BEATS) begin m_cnt = 0; m_mode = 2; end
                   end
                default: if (rdy) begin m_mode = start ? 1 : 0; m_cnt = 0; end
            endcase
`ifdef LANE_JOIN_ERR_EN
            if (new_err) m_err = 1'b1;
            else if (accepted) m_err = 1'b0;
`else
            if (new_err || accepted) m_err = 1'b0;
`endif
        end
    endtask

    // One clock: advance model with the inputs seen at the edge, then compare.
    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
        chk("vec",   W'(Vec_o),       W'(m_vec));
        chk("valid", W'(vec_valid_o), W'(m_mode == 2));
        chk("busy",  W'(busy_o),      W'(m_mode != 0));
        chk("beat",  W'(beat_o),      W'(m_cnt));
        chk("err",   W'(err_o),       W'(m_err));
    endtask

    task automatic beat_pattern(input int b);
        for (int l = 0; l < LANES; l++) res[l] = N'(100 * l + b);
    endtask

    initial begin
        // Reset state
        rst = 1'b0; cyc(); cyc();
        chk("rst_vec",   W'(Vec_o), W'(0));
        chk("rst_valid", W'(vec_valid_o), W'(0));
        rst = 1'b1;

        // Full vector with minimum latency: start at cycle 0, beats 1-5
        start = 1'b1; cyc(); start = 1'b0;
        lv = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            beat_pattern(b); cyc();
        end
        lv = 1'b0;
        chk("lat6_valid", W'(vec_valid_o), W'(1));
        chk("elem7",      W'(Vec_o[7]),    W'(102));
        chk("elem19",     W'(Vec_o[19]),   W'(304));

        // Backpressure: four cycles without ready, then accept to IDLE
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("bp_elem0", W'(Vec_o[0]), W'(0));
        rdy = 1'b1; cyc(); rdy = 1'b0;
        chk("bp_idle_valid", W'(vec_valid_o), W'(0));
        chk("bp_idle_busy",  W'(busy_o),      W'(0));

        // Stall after beat 2 for three cycles
        start = 1'b1; cyc(); start = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            beat_pattern(b + 10); lv = 1'b1; cyc();
            if (b == 2) begin
                lv = 1'b0;
                for (int s = 0; s < 3; s++) cyc();
                chk("stall_beat", W'(beat_o), W'(3));
            end
        end
        lv = 1'b0;
        chk("stall_valid", W'(vec_valid_o), W'(1));

        // Back-to-back: accept and restart in the same HOLD cycle
        rdy = 1'b1; start = 1'b1; cyc(); rdy = 1'b0; start = 1'b0;
        chk("b2b_beat",  W'(beat_o),      W'(0));
        chk("b2b_busy",  W'(busy_o),      W'(1));
        chk("b2b_valid", W'(vec_valid_o), W'(0));
        lv = 1'b1;
        for (int b = 0; b < BEATS; b++) begin beat_pattern(b + 20); cyc(); end
        lv = 1'b0;
        chk("b2b_done", W'(Vec_o[6]), W'(121));

        // Mid-operation reset at beat 3, then data without start
        rdy = 1'b1; cyc(); rdy = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        lv = 1'b1;
        for (int b = 0; b < 3; b++) begin beat_pattern(b + 30); cyc(); end
        rst = 1'b0; cyc(); rst = 1'b1;
        chk("mid_rst_vec", W'(Vec_o), W'(0));
        beat_pattern(40); cyc(); cyc();
        chk("no_capture", W'(Vec_o), W'(0));
        lv = 1'b0;

        // Error flag: data in IDLE, then cleared by an accepted start
        lv = 1'b1; cyc(); lv = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        chk("err_clear", W'(err_o), W'(0));
        rst = 1'b0; cyc(); rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 3) == 0);
            lv    = ($urandom_range(0, 9) < 7);
            rdy   = ($urandom_range(0, 1) == 1);
            for (int l = 0; l < LANES; l++) res[l] = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
